// File: rtl/tug_input_pulser.sv
// Player-input front end: synchronizes and debounces the active-low keys and emits one-cycle press pulses on L/R.
// Optional macro TUG_INPUT_PULSER_CPU_PLAYER_EN replaces the right player with an LFSR-driven computer opponent.
module tug_input_pulser #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PACE_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_l_n,
    input  logic       key_r_n,
    input  logic [9:0] difficulty,
    output logic       L,
    output logic       R
);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] key_n;
    logic [1:0] press;

    assign key_n = {key_r_n, key_l_n};

    // Index 0 is the left key, index 1 the right key; both paths are identical.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_key
            logic       sync1_q, sync1_d;
            logic       sync2_q, sync2_d;
            logic       st_q, st_d;
            logic [7:0] cnt_q, cnt_d;
            logic       press_q, press_d;

            always_comb begin
                sync1_d = ~key_n[gi];
                sync2_d = sync1_q;
                st_d    = st_q;
                cnt_d   = cnt_q;
                if (sync2_q == st_q) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    st_d  = ~st_q;
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                // Pulse only on the accepted released-to-pressed transition.
                press_d = st_d & ~st_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    st_q    <= 1'b0;
                    cnt_q   <= 8'd0;
                    press_q <= 1'b0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    st_q    <= st_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    assign L = press[0];

`ifdef TUG_INPUT_PULSER_CPU_PLAYER_EN
    localparam logic [15:0] PACE_LAST = 16'(PACE_CYCLES - 1);

    logic [9:0]  lfsr_q, lfsr_d;
    logic [15:0] pace_q, pace_d;
    logic        r_q, r_d;
    logic        unused_key_r;

    always_comb begin
        // Fibonacci x^10 + x^7 + 1; seeded non-zero so it never locks up.
        lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        pace_d = (pace_q == PACE_LAST) ? 16'd0 : pace_q + 16'd1;
        r_d    = (pace_q == PACE_LAST) && (difficulty > lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 10'h001;
            pace_q <= 16'd0;
            r_q    <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            pace_q <= pace_d;
            r_q    <= r_d;
        end
    end

    // The right key path stays built so both builds share one key front end.
    assign unused_key_r = press[1];
    assign R            = r_q;
`else
    logic unused_difficulty;

    assign unused_difficulty = ^difficulty;
    assign R                 = press[1];
`endif

endmodule

// File: tb/tb_tug_input_pulser.sv
// Directed bench for tug_input_pulser: window-based behavioural model checked every cycle plus literal pulse checks.
`timescale 1ns/1ps
module tb_tug_input_pulser;
    localparam int D = 4;
    localparam int P = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_l_n = 1'b1;
    logic       key_r_n = 1'b1;
    logic [9:0] difficulty = 10'd0;
    logic       L;
    logic       R;

    tug_input_pulser #(.DEBOUNCE_CYCLES(D), .PACE_CYCLES(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_l_n    (key_l_n),
        .key_r_n    (key_r_n),
        .difficulty (difficulty),
        .L          (L),
        .R          (R)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: a key level is accepted once the twice-delayed raw samples have
    // disagreed with the accepted level for D consecutive samples.
    bit [D+1:0] hist_l = '0;
    bit [D+1:0] hist_r = '0;
    bit         st_l_m = 1'b0;
    bit         st_r_m = 1'b0;
    bit         exp_l = 1'b0;
    bit         exp_r = 1'b0;
    int         k = 0;
    bit [9:0]   lfsr_m = 10'h001;

    function automatic bit window_differs(bit [D+1:0] h, bit st);
        for (int i = 2; i < D + 2; i++) begin
            if (h[i] == st) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            hist_l = '0;
            hist_r = '0;
            st_l_m = 1'b0;
            st_r_m = 1'b0;
            exp_l  = 1'b0;
            exp_r  = 1'b0;
            k      = 0;
            lfsr_m = 10'h001;
        end else begin
            bit rise_r;
            hist_l = {hist_l[D:0], ~key_l_n};
            hist_r = {hist_r[D:0], ~key_r_n};
            exp_l  = 1'b0;
            rise_r = 1'b0;
            if (window_differs(hist_l, st_l_m)) begin
                st_l_m = ~st_l_m;
                exp_l  = st_l_m;
            end
            if (window_differs(hist_r, st_r_m)) begin
                st_r_m = ~st_r_m;
                rise_r = st_r_m;
            end
`ifdef TUG_INPUT_PULSER_CPU_PLAYER_EN
            exp_r  = ((k % P) == P - 1) && (difficulty > lfsr_m);
            lfsr_m = {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
            k++;
`else
            exp_r = rise_r;
`endif
        end
    end

    task automatic check_bit(string name, logic act, logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, expv);
        end
    endtask

    task automatic lit(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    int l_tot = 0;
    int r_tot = 0;
    int l_at = -1;
    int r_at = -1;

    always @(negedge clk) begin
        check_bit("L_model", L, exp_l);
        check_bit("R_model", R, exp_r);
        if (L === 1'b1) begin
            l_tot++;
            l_at = cyc;
        end
        if (R === 1'b1) begin
            r_tot++;
            r_at = cyc;
        end
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    int l_base;
    int r_base;
    int t0;

    task automatic mark();
        l_base = l_tot;
        r_base = r_tot;
    endtask

    initial begin
        reset = 1'b1;
        cycles(2);
        lit("reset_L", int'(L), 0);
        lit("reset_R", int'(R), 0);
        reset = 1'b0;
        cycles(3);

        // Clean left press: pulse after edge D+1 counted from the first sampling edge.
        mark();
        key_l_n = 1'b0;
        t0 = cyc;
        cycles(20);
        lit("clean_l_count", l_tot - l_base, 1);
        lit("clean_l_latency", l_at - t0, D + 2);
        lit("clean_r_count", r_tot - r_base, 0);
        key_l_n = 1'b1;
        cycles(12);
        lit("release_no_pulse", l_tot - l_base, 1);

        // Bounce every 2 cycles for 16 cycles.
        mark();
        for (int i = 0; i < 8; i++) begin
            key_l_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        key_l_n = 1'b1;
        cycles(12);
        lit("bounce_l_count", l_tot - l_base, 0);

        // Glitch of D-1 cycles is rejected, exactly D cycles is accepted.
        mark();
        key_l_n = 1'b0;
        cycles(D - 1);
        key_l_n = 1'b1;
        cycles(12);
        lit("glitch_short", l_tot - l_base, 0);
        mark();
        key_l_n = 1'b0;
        cycles(D);
        key_l_n = 1'b1;
        cycles(12);
        lit("glitch_exact", l_tot - l_base, 1);

        // Release and repress.
        mark();
        key_l_n = 1'b0;
        cycles(10);
        key_l_n = 1'b1;
        cycles(10);
        key_l_n = 1'b0;
        cycles(10);
        key_l_n = 1'b1;
        cycles(12);
        lit("repress_l_count", l_tot - l_base, 2);

        // Simultaneous presses.
        mark();
        key_l_n = 1'b0;
        key_r_n = 1'b0;
        t0 = cyc;
        cycles(12);
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        cycles(12);
        lit("simul_l_count", l_tot - l_base, 1);
`ifndef TUG_INPUT_PULSER_CPU_PLAYER_EN
        lit("simul_r_count", r_tot - r_base, 1);
        lit("simul_same_cycle", l_at - r_at, 0);
        lit("simul_r_latency", r_at - t0, D + 2);
`endif

        // Reset two cycles into a press, key held through reset.
        mark();
        key_l_n = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(3);
        lit("midreset_no_pulse", l_tot - l_base, 0);
        reset = 1'b0;
        t0 = cyc;
        cycles(12);
        lit("midreset_l_count", l_tot - l_base, 1);
        lit("midreset_latency", l_at - t0, D + 2);
        key_l_n = 1'b1;
        cycles(12);

`ifdef TUG_INPUT_PULSER_CPU_PLAYER_EN
        difficulty = 10'd0;
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        mark();
        cycles(200);
        lit("cpu_diff0_r_count", r_tot - r_base, 0);

        difficulty = 10'h3FF;
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        mark();
        for (int i = 0; i < 10; i++) begin
            key_r_n = ~key_r_n;
            cycles(P);
        end
        key_r_n = 1'b1;
        lit("cpu_full_r_ge9", int'((r_tot - r_base) >= 9), 1);
        lit("cpu_full_r_le10", int'((r_tot - r_base) <= 10), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
